// File: rtl/mau_nbank.sv
`default_nettype none
// ============================================================================
// Module   : mau_nbank
// Purpose  : Matrix algebra unit with NUM_BANKS register-file banks, each
//            holding MATRIX_DIM x MATRIX_DIM elements of ELEM_W bits. The
//            host streams matrices in (LOAD) and out (STORE) one element per
//            cycle and issues element-wise ops between banks (EXEC) through a
//            single shared ALU.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            instr/_valid/_ready - {OP[2:0], DST, SRCA, SRCB} command channel
//            data_in/in_valid/in_ready    - LOAD element stream (row-major)
//            data_out/out_valid/out_ready - STORE element stream (row-major)
//            busy, done, err     - status; done/err are one-cycle pulses
// Revision : 1.0 - initial release
// ============================================================================
module mau_nbank #(
    parameter int MATRIX_DIM = 8,
    parameter int ELEM_W     = 8,
    parameter int NUM_BANKS  = 4,
    parameter int SATURATE   = 0,
    localparam int BW        = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3+3*BW-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [ELEM_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ELEM_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                c_elems  = MATRIX_DIM * MATRIX_DIM;
    localparam int                c_cw     = (c_elems > 1) ? $clog2(c_elems) : 1;
    localparam logic [c_cw-1:0]   c_last   = c_cw'(c_elems - 1);
    localparam logic [BW:0]       c_nbanks = (BW+1)'(NUM_BANKS);
    localparam logic [ELEM_W-1:0] c_shmax  = ELEM_W'(ELEM_W);

    localparam logic [2:0] c_op_nop   = 3'b000;
    localparam logic [2:0] c_op_load  = 3'b001;
    localparam logic [2:0] c_op_store = 3'b010;
    localparam logic [2:0] c_op_add   = 3'b011;
    localparam logic [2:0] c_op_sub   = 3'b100;
    localparam logic [2:0] c_op_shl   = 3'b101;
    localparam logic [2:0] c_op_mul   = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [c_cw-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [BW-1:0]     dst_q, dst_d;
    logic [BW-1:0]     srca_q, srca_d;
    logic [BW-1:0]     srcb_q, srcb_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ELEM_W-1:0] bank_q [NUM_BANKS][c_elems];

    logic              wr_en;
    logic [ELEM_W-1:0] wr_data;

    logic [ELEM_W-1:0] op_a, op_b, prod, alu_res;
    logic [ELEM_W:0]   sum_ext, diff_ext;

    logic [2:0]        in_op;
    logic [BW-1:0]     in_dst, in_srca, in_srcb;

    assign in_op   = instr[3+3*BW-1 -: 3];
    assign in_dst  = instr[3*BW-1 -: BW];
    assign in_srca = instr[2*BW-1 -: BW];
    assign in_srcb = instr[BW-1:0];

    // A bank field is only illegal when NUM_BANKS is not a power of two.
    function automatic logic bank_bad(input logic [BW-1:0] f);
        return ({1'b0, f} >= c_nbanks);
    endfunction

    // Element-wise ALU. Reads and writes of the same element happen in the
    // same cycle, so in-place operation needs no extra buffering.
    always_comb begin
        op_a     = bank_q[srca_q][cnt_q];
        op_b     = bank_q[srcb_q][cnt_q];
        sum_ext  = {1'b0, op_a} + {1'b0, op_b};
        diff_ext = {1'b0, op_a} - {1'b0, op_b};   // MSB set means borrow
        prod     = op_a * op_b;
        alu_res  = op_a;
        case (op_q)
            c_op_add: alu_res = (SATURATE != 0 && sum_ext[ELEM_W])  ? '1 : sum_ext[ELEM_W-1:0];
            c_op_sub: alu_res = (SATURATE != 0 && diff_ext[ELEM_W]) ? '0 : diff_ext[ELEM_W-1:0];
            c_op_shl: alu_res = (op_b >= c_shmax) ? '0 : (op_a << op_b);
            c_op_mul: alu_res = prod;
            default:  alu_res = op_a;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dst_d   = dst_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_data = alu_res;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d   = in_op;
                    dst_d  = in_dst;
                    srca_d = in_srca;
                    srcb_d = in_srcb;
                    cnt_d  = '0;
                    case (in_op)
                        c_op_nop: done_d = 1'b1;
                        c_op_load: begin
                            if (bank_bad(in_dst)) begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end else begin
                                state_d = S_LOAD;
                            end
                        end
                        c_op_store: begin
                            if (bank_bad(in_srca)) begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end else begin
                                state_d = S_STORE;
                            end
                        end
                        default: begin
                            if (bank_bad(in_dst) || bank_bad(in_srca) || bank_bad(in_srcb)) begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end else begin
                                state_d = S_EXEC;
                            end
                        end
                    endcase
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_data = data_in;
                end
            end
            S_STORE: ;
            S_EXEC: wr_en = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Shared element-step / completion logic for the three streaming states.
        if ((state_q == S_LOAD && in_valid) || (state_q == S_STORE && out_ready) ||
            state_q == S_EXEC) begin
            if (cnt_q == c_last) begin
                cnt_d   = '0;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            dst_q   <= '0;
            srca_q  <= '0;
            srcb_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int e = 0; e < c_elems; e++) begin
                    bank_q[b][e] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (wr_en) begin
                bank_q[dst_q][cnt_q] <= wr_data;
            end
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign in_ready    = (state_q == S_LOAD);
    assign out_valid   = (state_q == S_STORE);
    assign data_out    = (state_q == S_STORE) ? bank_q[srca_q][cnt_q] : '0;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mau_nbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_mau_nbank
// Purpose  : Directed self-checking bench for mau_nbank. Two instances run in
//            lockstep on shared stimulus: u_a (4 banks, wrapping arithmetic)
//            and u_b (3 banks, saturating arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mau_nbank;

    logic       clk;
    logic       rst;
    logic [8:0] instr;
    logic       instr_valid;
    logic [7:0] data_in;
    logic       in_valid;
    logic       out_ready;

    logic       a_instr_ready, a_in_ready, a_out_valid, a_busy, a_done, a_err;
    logic       b_instr_ready, b_in_ready, b_out_valid, b_busy, b_done, b_err;
    logic [7:0] a_data_out, b_data_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_a [64];
    logic [7:0] exp_b [64];

    localparam logic [2:0] OP_NOP = 3'b000, OP_LOAD = 3'b001, OP_STORE = 3'b010,
                           OP_ADD = 3'b011, OP_SUB = 3'b100, OP_SHL = 3'b101,
                           OP_MUL = 3'b110, OP_COPY = 3'b111;

    mau_nbank #(.MATRIX_DIM(8), .ELEM_W(8), .NUM_BANKS(4), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(a_instr_ready), .data_in(data_in), .in_valid(in_valid),
        .in_ready(a_in_ready), .data_out(a_data_out), .out_valid(a_out_valid),
        .out_ready(out_ready), .busy(a_busy), .done(a_done), .err(a_err)
    );

    mau_nbank #(.MATRIX_DIM(8), .ELEM_W(8), .NUM_BANKS(3), .SATURATE(1)) u_b (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(b_instr_ready), .data_in(data_in), .in_valid(in_valid),
        .in_ready(b_in_ready), .data_out(b_data_out), .out_valid(b_out_valid),
        .out_ready(out_ready), .busy(b_busy), .done(b_done), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_exp(input logic [7:0] va, input logic [7:0] vb);
        for (int i = 0; i < 64; i++) begin
            exp_a[i] = va;
            exp_b[i] = vb;
        end
    endtask

    // Tasks start and end just after a falling edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb);
        int guard = 0;
        while (!(a_instr_ready && b_instr_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk_eq("issue_wait", guard < 200, 1);
        instr       = {op, dst, sa, sb};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic load_fill(input logic [1:0] bank, input logic [7:0] base, input logic [7:0] step);
        issue(OP_LOAD, bank, 2'd0, 2'd0);
        for (int i = 0; i < 64; i++) begin
            data_in  = base + 8'(i) * step;
            in_valid = 1'b1;
            if (i == 0)  chk_eq("load_rdy", {a_in_ready, b_in_ready, a_busy, b_busy}, 4'b1111);
            if (i == 63) chk_eq("load_early_done", {a_done, b_done}, 2'b00);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk_eq("load_done", {a_done, b_done, a_err, b_err, a_busy, b_busy}, 6'b110000);
    endtask

    task automatic store_chk(input logic [1:0] bank, input bit toggle, input string tag);
        int n   = 0;
        int cyc = 0;
        issue(OP_STORE, bank, bank, 2'd0);
        while (n < 64 && cyc < 400) begin
            out_ready = toggle ? cyc[0] : 1'b1;
            // Checked every cycle, so a stalled cycle also proves data_out held.
            chk_eq($sformatf("%s[%0d]", tag, n),
                   {a_out_valid, b_out_valid, a_data_out, b_data_out},
                   {2'b11, exp_a[n], exp_b[n]});
            if (out_ready) n++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk_eq({tag, "_count"}, n, 64);
        chk_eq({tag, "_cycles"}, cyc, toggle ? 128 : 64);
        chk_eq({tag, "_done"}, {a_done, b_done, a_out_valid, b_out_valid, a_data_out}, {4'b1100, 8'h00});
    endtask

    task automatic exec_timed(input logic [2:0] op, input logic [1:0] dst,
                              input logic [1:0] sa, input logic [1:0] sb, input string tag);
        int cyc = 1;
        issue(op, dst, sa, sb);
        while (!a_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk_eq({tag, "_latency"}, cyc, 65);
        chk_eq({tag, "_status"}, {a_done, b_done, a_err, b_err, a_instr_ready, b_instr_ready},
               6'b110011);
    endtask

    initial begin
        int cyc;
        rst         = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        data_in     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk_eq("reset_a", {a_busy, a_instr_ready, a_done, a_err, a_in_ready, a_out_valid, a_data_out},
               {6'b010000, 8'h00});
        chk_eq("reset_b", {b_busy, b_instr_ready, b_done, b_err, b_in_ready, b_out_valid, b_data_out},
               {6'b010000, 8'h00});

        // NOP: done in the cycle after accept, while idle.
        issue(OP_NOP, 2'd0, 2'd0, 2'd0);
        chk_eq("nop_done", {a_done, a_err, b_done, b_err, a_busy, a_instr_ready}, 6'b101001);
        @(negedge clk);
        chk_eq("nop_pulse_end", {a_done, b_done}, 2'b00);

        // Illegal SRCB=3 on the 3-bank instance; the 4-bank one executes it.
        load_fill(2'd1, 8'd7, 8'd0);
        issue(OP_ADD, 2'd0, 2'd1, 2'd3);
        chk_eq("illegal_b", {b_done, b_err, b_busy, a_done, a_busy}, 5'b11001);
        @(negedge clk);
        chk_eq("illegal_pulse_end", {b_done, b_err}, 2'b00);
        cyc = 0;
        while (!a_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk_eq("illegal_a_exec", a_done, 1);
        set_exp(8'd7, 8'd0);
        store_chk(2'd0, 1'b0, "illegal_st0");
        set_exp(8'd7, 8'd7);
        store_chk(2'd1, 1'b0, "illegal_st1");

        // Ramp load and read back.
        load_fill(2'd0, 8'd0, 8'd1);
        for (int i = 0; i < 64; i++) begin
            exp_a[i] = 8'(i);
            exp_b[i] = 8'(i);
        end
        store_chk(2'd0, 1'b0, "ramp");

        // Wrap vs saturate.
        load_fill(2'd1, 8'd200, 8'd0);
        load_fill(2'd2, 8'd100, 8'd0);
        exec_timed(OP_ADD, 2'd0, 2'd1, 2'd2, "add");
        set_exp(8'd44, 8'd255);
        store_chk(2'd0, 1'b1, "add_tog");
        exec_timed(OP_SUB, 2'd0, 2'd2, 2'd1, "sub");
        set_exp(8'd156, 8'd0);
        store_chk(2'd0, 1'b0, "sub");

        // Shift left, in range and out of range.
        load_fill(2'd1, 8'h21, 8'd0);
        load_fill(2'd2, 8'd3, 8'd0);
        exec_timed(OP_SHL, 2'd0, 2'd1, 2'd2, "shl3");
        set_exp(8'h08, 8'h08);
        store_chk(2'd0, 1'b0, "shl3");
        load_fill(2'd2, 8'd9, 8'd0);
        exec_timed(OP_SHL, 2'd0, 2'd1, 2'd2, "shl9");
        set_exp(8'h00, 8'h00);
        store_chk(2'd0, 1'b0, "shl9");

        // Multiply (low byte) and copy.
        load_fill(2'd1, 8'd16, 8'd0);
        load_fill(2'd2, 8'd17, 8'd0);
        exec_timed(OP_MUL, 2'd0, 2'd1, 2'd2, "mul");
        set_exp(8'h10, 8'h10);
        store_chk(2'd0, 1'b0, "mul");
        exec_timed(OP_COPY, 2'd0, 2'd2, 2'd1, "copy");
        set_exp(8'd17, 8'd17);
        store_chk(2'd0, 1'b0, "copy");

        // In-place add.
        load_fill(2'd2, 8'd5, 8'd0);
        exec_timed(OP_ADD, 2'd2, 2'd2, 2'd2, "inplace");
        set_exp(8'd10, 8'd10);
        store_chk(2'd2, 1'b0, "inplace");

        // Reset in the middle of a LOAD.
        issue(OP_LOAD, 2'd1, 2'd0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            data_in  = 8'hAA;
            in_valid = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_eq("midrst", {a_busy, b_busy, a_instr_ready, b_instr_ready, a_done, b_done}, 6'b001100);
        set_exp(8'd0, 8'd0);
        store_chk(2'd1, 1'b0, "midrst_st1");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
